imem_loader: RTL

//  Write-side counterpart of the instruction memory read port: receives a byte stream (valid/ready),

---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_word_packer.sv | 40 ++++
 rtl/imem_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encodings for the instruction memory loader.
// Also provides the default instruction memory geometry used by the memory itself.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit checksum word).
package imem_loader_pkg;

   localparam int unsigned IMEM_DEPTH  = 1061;
   localparam int unsigned IMEM_ADDR_W = 11;
   localparam int unsigned IMEM_BASE   = 0;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BIDX_W = 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   // True when an image of n words starting at base fits in a memory of depth words
   function automatic logic image_fits(input logic [WORD_W-1:0] n,
                                       input int unsigned base,
                                       input int unsigned depth);
      return ({1'b0, n} + 33'(base)) <= 33'(depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction memory write port of the loader.
// master: host side (drives bytes, observes writes); slave: loader side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W
);

   logic                rx_valid;
   logic [BYTE_W-1:0]   rx_data;
   logic                rx_ready;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [WORD_W-1:0]   mem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_waddr, mem_wdata
   );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// The completed word is presented combinationally in the cycle its 4th byte is accepted.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word_c,
   output logic              o_word_valid_c
);

   logic [BIDX_W-1:0]       r_idx;
   logic [3*BYTE_W-1:0]     r_low;

   // Byte index (wraps 3->0) and storage for the three lower bytes of the word in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
         r_low <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_low <= '0;
      end else if (i_valid) begin
         r_idx <= r_idx + BIDX_W'(1);
         case (r_idx)
            2'd0:    r_low[7:0]   <= i_byte;
            2'd1:    r_low[15:8]  <= i_byte;
            2'd2:    r_low[23:16] <= i_byte;
            default: r_low        <= r_low;
         endcase
      end
   end

   assign o_word_c       = {i_byte, r_low};
   assign o_word_valid_c = i_valid & (r_idx == BIDX_W'(3));

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: header word N, then N data words written from BASE upward.
// Holds the core for the whole load so fetch never sees a partial image.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit wrapping-sum check.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH  = IMEM_DEPTH,
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned BASE   = IMEM_BASE
)(
   input  logic         clock,
   input  logic         reset,
   input  logic         i_start,
   imem_loader_if.slave bus,
   output logic         o_core_hold,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_error
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   state_t              r_state;
   logic                r_rx_ready;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_waddr;
   logic [WORD_W-1:0]   r_mem_wdata;
   logic [ADDR_W-1:0]   r_addr;
   logic [CNT_W-1:0]    r_n;
   logic [CNT_W-1:0]    r_wcount;
   logic                r_core_hold;
   logic                r_busy;
   logic                r_done;
   logic                r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]   r_sum;
`endif

   logic                w_accept;
   logic                w_start;
   logic [WORD_W-1:0]   w_word;
   logic                w_word_valid;
   logic [CNT_W-1:0]    w_wcount_nxt;
   logic                w_last_word;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_fits;

   assign w_accept     = bus.rx_valid & r_rx_ready;
   assign w_start      = i_start & (r_state inside {S_IDLE, S_DONE, S_ERR});
   assign w_wcount_nxt = r_wcount + CNT_W'(1);
   assign w_last_word  = (w_wcount_nxt == r_n);
   assign w_addr_nxt   = (r_addr == ADDR_W'(DEPTH - 1)) ? r_addr : r_addr + ADDR_W'(1);
   assign w_fits       = image_fits(w_word, BASE, DEPTH);

   imem_word_packer u_packer (
      .clock          (clock),
      .reset          (reset),
      .i_clear        (w_start),
      .i_valid        (w_accept),
      .i_byte         (bus.rx_data),
      .o_word_c       (w_word),
      .o_word_valid_c (w_word_valid)
   );

   // Load sequencer: state, handshake, memory write port, counters and status flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rx_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_addr      <= '0;
         r_n         <= '0;
         r_wcount    <= '0;
         r_core_hold <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_sum       <= '0;
`endif
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (w_start) begin
                  r_state     <= S_HDR;
                  r_rx_ready  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_core_hold <= 1'b1;
                  r_done      <= 1'b0;
                  r_error     <= 1'b0;
                  r_wcount    <= '0;
                  r_addr      <= ADDR_W'(BASE);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_sum       <= '0;
`endif
               end
            end

            S_HDR: begin
               if (w_word_valid) begin
                  if (!w_fits) begin
                     r_state     <= S_ERR;
                     r_error     <= 1'b1;
                     r_rx_ready  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_core_hold <= 1'b0;
                  end else if (w_word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state     <= S_CSUM;
`else
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_rx_ready  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_core_hold <= 1'b0;
`endif
                  end else begin
                     r_state <= S_DATA;
                     r_n     <= CNT_W'(w_word);
                  end
               end
            end

            S_DATA: begin
               if (w_word_valid) begin
                  r_mem_we    <= 1'b1;
                  r_mem_waddr <= r_addr;
                  r_mem_wdata <= w_word;
                  r_addr      <= w_addr_nxt;
                  r_wcount    <= w_wcount_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_sum       <= r_sum + w_word;
                  if (w_last_word) begin
                     r_state <= S_CSUM;
                  end
`else
                  // Stop taking bytes; completion is flagged once the last write has issued
                  if (w_last_word) begin
                     r_rx_ready <= 1'b0;
                  end
`endif
               end
`ifndef IMEM_LOADER_CHECKSUM_EN
               else if (r_wcount == r_n) begin
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_core_hold <= 1'b0;
               end
`endif
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_word_valid) begin
                  r_rx_ready  <= 1'b0;
                  r_busy      <= 1'b0;
                  r_core_hold <= 1'b0;
                  if (w_word == r_sum) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_error <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               r_state     <= S_IDLE;
               r_rx_ready  <= 1'b0;
               r_busy      <= 1'b0;
               r_core_hold <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_ready  = r_rx_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_waddr = r_mem_waddr;
   assign bus.mem_wdata = r_mem_wdata;
   assign o_core_hold   = r_core_hold;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_error       = r_error;

endmodule
